// File: rtl/cli_line_buffer.sv
// rtl/cli_line_buffer.sv - UART command-line assembler with edit handling, echo and line handoff
// Pops RX bytes, edits a line buffer, echoes each keystroke and holds a CR-terminated line for the consumer.
module cli_line_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          rx_fifo_pop,
  input  logic          tx_fifo_full,
  output logic          transmit,
  output logic [7:0]    tx_byte,
  output logic          line_ready,
  output logic [AW:0]   line_len,
  output logic          line_overflow,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          line_ack
);

  typedef enum logic [1:0] {IDLE, DECODE, ECHO, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  rx_q;
  logic [23:0] echo_sh;
  logic [1:0]  echo_cnt;
  logic        echo_cr;
  logic [7:0]  mem [DEPTH];

  logic        is_print, is_bs, is_cr, full, empty;
  logic [1:0]  load_cnt;
  logic [23:0] load_sh;

  // Echo bytes are loaded LSB-first so tx_byte is always the low byte of the shifter.
  always_comb begin
    is_print = (rx_q >= 8'h20) && (rx_q <= 8'h7E);
    is_bs    = (rx_q == 8'h08) || (rx_q == 8'h7F);
    is_cr    = (rx_q == 8'h0D);
    full     = line_len[AW];
    empty    = (line_len == '0);
    load_cnt = 2'd0;
    load_sh  = 24'h0;
    if (is_print) begin
      load_cnt = 2'd1;
      load_sh  = full ? 24'h000007 : {16'h0, rx_q};
    end else if (is_bs) begin
      load_cnt = empty ? 2'd1 : 2'd3;
      load_sh  = empty ? 24'h000007 : 24'h082008;
    end else if (is_cr) begin
      load_cnt = 2'd2;
      load_sh  = 24'h000A0D;
    end
  end

  always_comb begin
    state_nx    = state;
    rx_fifo_pop = 1'b0;
    transmit    = 1'b0;
    case (state)
      IDLE: begin
        // Qualified by rst so the pop strobe is quiet while reset is held.
        if (rx_valid && rst) begin
          rx_fifo_pop = 1'b1;
          state_nx    = DECODE;
        end
      end
      DECODE: state_nx = (load_cnt != 2'd0) ? ECHO : IDLE;
      ECHO: begin
        if (!tx_fifo_full) begin
          transmit = 1'b1;
          if (echo_cnt == 2'd1) state_nx = echo_cr ? DONE : IDLE;
        end
      end
      DONE: if (line_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign tx_byte    = echo_sh[7:0];
  assign line_ready = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rx_q          <= 8'h00;
      echo_sh       <= 24'h0;
      echo_cnt      <= 2'd0;
      echo_cr       <= 1'b0;
      line_len      <= '0;
      line_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (rx_fifo_pop) rx_q <= rx_byte;
      case (state)
        DECODE: begin
          echo_sh  <= load_sh;
          echo_cnt <= load_cnt;
          echo_cr  <= is_cr;
          if (is_print && !full) line_len <= line_len + 1'b1;
          if (is_print && full) line_overflow <= 1'b1;
          if (is_bs && !empty) line_len <= line_len - 1'b1;
        end
        ECHO: begin
          if (transmit) begin
            echo_sh  <= {8'h00, echo_sh[23:8]};
            echo_cnt <= echo_cnt - 2'd1;
          end
        end
        DONE: begin
          if (line_ack) begin
            line_len      <= '0;
            line_overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DECODE && is_print && !full) mem[line_len[AW-1:0]] <= rx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= 8'h00;
    else      rd_data <= mem[rd_addr];
  end

endmodule
